ntt_core_wmm_clbu_pp_tag_gen_chk: RTL and testbench
===================================================

Name: ntt_core_wmm_clbu_pp_tag_gen_chk

Overview:
- Parametrised tagged-data stimulus generator plus in-order checker for CLBU+PP (butterfly plus post-process) verification in the NTT-with-matrix-multiplication core.
- Generates CHAN_NB lanes per word; each lane packs {val, batch_id, pbs_id, stg_iter} into OP_W bits.
- Independently checks the stream returning from the DUT against the same expected sequence.
- Generalises the fixed single-lane tag layout to configurable field widths, lane count, batch size and batch count, and adds handshake plus error reporting.

Parameters:
OP_W, 64, lane width (MOD_NTT_W)
CHAN_NB, 8, lanes per word (PSI*R)
BATCH_NB_W, 16, batch_id field width
PBS_ID_W, 4, pbs_id field width
STG_ITER_W, 5, stg_iter field width
STG_ITER_NB, 16, stage iterations per batch (<= 2**STG_ITER_W)
VAL_W, OP_W-BATCH_NB_W-PBS_ID_W-STG_ITER_W, payload width; elaboration error if < 1

Ports:
clk  in  1  clock
s_rst  in  1  synchronous active-high reset
start  in  1  pulse: latch cfg, clear counters/errors, begin run
cfg_pbs_nb  in  PBS_ID_W+1  PBS per batch, legal 1..2**PBS_ID_W
cfg_batch_nb  in  BATCH_NB_W  batches to generate; 0 = unlimited
gen_avail  out  1  generated word valid
gen_data  out  CHAN_NB*OP_W  generated word, lane c at [c*OP_W +: OP_W]
gen_rdy  in  1  consumer accepts
gen_done  out  1  run finished (level)
chk_avail  in  1  returned word valid
chk_data  in  CHAN_NB*OP_W  returned word
chk_rdy  out  1  checker ready
chk_err  out  1  sticky error flag
chk_err_code  out  2  first error: 1 tag, 2 val, 3 lane inconsistency
chk_err_idx  out  32  word index of first error
chk_cnt  out  32  words checked

Behaviour:
- Sequence order, outermost to innermost: batch b (0..), stg_iter s (0..STG_ITER_NB-1), pbs p (0..cfg_pbs_nb-1).
- Word index w counts from 0 per run.
- Lane c fields: batch_id = b mod 2**BATCH_NB_W, pbs_id = p, stg_iter = s, val = (c + w) mod 2**VAL_W.
- Field order MSB->LSB: val, batch_id, pbs_id, stg_iter.
- Generator FSM:
  - IDLE: start -> RUN; cfg latched that cycle.
  - RUN: gen_avail = 1 from the cycle after start. Transfer when gen_avail & gen_rdy; next word appears the next cycle (back-to-back allowed).
  - RUN -> DONE: on transfer of the last word of batch cfg_batch_nb-1. Unlimited mode never leaves RUN. batch_id wraps mod 2**BATCH_NB_W.
  - DONE: gen_done = 1, gen_avail = 0. start -> RUN.
  - start during RUN: ignored.
- gen_data stable while gen_avail & !gen_rdy; registered output, no combinational path from gen_rdy.
- Checker:
  - Own expected counters (b, s, p, w), reset by start.
  - chk_rdy = 1 in every cycle except reset and the first cycle after it.
  - On transfer (chk_avail & chk_rdy), set the following cycle:
    - chk_cnt increments.
    - Lanes disagree on any tag -> code 3.
    - Else tag != expected -> code 1.
    - Else any val wrong -> code 2.
  - Only the first error is recorded (code, idx = chk_cnt at the erroring transfer). chk_err stays sticky until start or s_rst.
  - Checker continues advancing expected counters after an error.
- Simultaneous start and chk transfer: start wins; that transfer is discarded and not counted.
- cfg_pbs_nb = 0 or > 2**PBS_ID_W: treated as 1.
- Reset mid-run: next cycle state IDLE, all outputs 0 (gen_avail, gen_done, chk_err, chk_err_code, chk_err_idx, chk_cnt, chk_rdy, gen_data).
- chk_cnt and chk_err_idx saturate at 2**32-1.

Decomposition:
- Shared package ntt_core_wmm_clbu_pp_tag_pkg:
  - Parametric tag field widths and the ERR_* code constants.
  - Function pack_lane(val, b, p, s) and the matching unpack, used by both halves.
- Sub-module ntt_core_wmm_clbu_pp_tag_cnt: the b/s/p/w nested counter with wrap, instantiated twice (generator and checker).

Test Plan:
- cfg_pbs_nb = 3, cfg_batch_nb = 2, gen looped to chk, gen_rdy = 1:
  - Expect 96 words; word 0 lane 5 val = 5, word 4 = {b0, s1, p1}.
  - gen_done after word 95; chk_cnt = 96; chk_err = 0.
- gen_rdy random 50%: gen_data never changes while stalled; same 96-word sequence; no error.
- Corrupt lane 2 pbs_id of word 10 only -> chk_err_code = 3, chk_err_idx = 10. Later correct words leave the code unchanged.
- Corrupt val of all lanes at word 7 -> code 2, idx 7.
- Drop word 20 (skip it) -> code 1, idx 20.
- Unlimited mode, BATCH_NB_W = 2: batch_id wraps to 0 after batch 3; s_rst asserted mid-word -> all outputs 0 next cycle. Restart via start reproduces word 0.

Source files
------------

// File: rtl/ntt_core_wmm_clbu_pp_tag_pkg.sv
// Shared definitions for the CLBU+PP tagged-data generator/checker: lane
// field packing helpers, generator states and checker error codes.
package ntt_core_wmm_clbu_pp_tag_pkg;

    // Helpers work on a generous fixed width; callers truncate to their OP_W.
    localparam int LANE_MAX_W = 256;

    typedef logic [LANE_MAX_W-1:0] lane_t;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_RUN,
        GEN_DONE
    } gen_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TAG  = 2'd1;
    localparam logic [1:0] ERR_VAL  = 2'd2;
    localparam logic [1:0] ERR_LANE = 2'd3;

    function automatic lane_t fld_mask(input int w);
        return (lane_t'(1) << w) - lane_t'(1);
    endfunction

    // Layout MSB->LSB: val, batch_id, pbs_id, stg_iter. val is left unmasked:
    // truncating the result to OP_W reduces it modulo 2**VAL_W.
    function automatic lane_t pack_lane(input lane_t val, input lane_t b,
                                        input lane_t p, input lane_t s,
                                        input int bw, input int pw, input int sw);
        return (val << (bw + pw + sw))
             | ((b & fld_mask(bw)) << (pw + sw))
             | ((p & fld_mask(pw)) << sw)
             | (s & fld_mask(sw));
    endfunction

    function automatic lane_t unpack_field(input lane_t lane, input int lsb, input int w);
        return (lane >> lsb) & fld_mask(w);
    endfunction

endpackage

// File: rtl/ntt_core_wmm_clbu_pp_tag_cnt.sv
// Nested batch / stage-iteration / pbs counter plus flat word index; one copy
// sequences the generator, another tracks what the checker expects next.
module ntt_core_wmm_clbu_pp_tag_cnt
    import ntt_core_wmm_clbu_pp_tag_pkg::*;
#(
    parameter int BATCH_NB_W  = 16,
    parameter int PBS_ID_W    = 4,
    parameter int STG_ITER_W  = 5,
    parameter int STG_ITER_NB = 16
) (
    input  logic                  clk,
    input  logic                  s_rst,
    input  logic                  clr,
    input  logic                  adv,
    input  logic [PBS_ID_W:0]     pbs_nb,
    output logic [BATCH_NB_W-1:0] b,
    output logic [STG_ITER_W-1:0] s,
    output logic [PBS_ID_W-1:0]   p,
    output logic [31:0]           w
);

    localparam logic [STG_ITER_W-1:0] S_LAST = STG_ITER_W'(STG_ITER_NB - 1);

    logic p_last;
    logic s_last;

    assign p_last = ({1'b0, p} == pbs_nb - 1'b1);
    assign s_last = (s == S_LAST);

    // NOTE: reset is synchronous, so it sits inside the clocked block and
    // simply takes priority over every other update.
    always_ff @(posedge clk) begin
        if (s_rst || clr) begin
            b <= '0;
            s <= '0;
            p <= '0;
            w <= '0;
        end else if (adv) begin
            // NOTE: non-blocking assignments keep all counter digits reading
            // the pre-edge values, so the carry chain below is order-free.
            w <= w + 32'd1;
            if (p_last) begin
                p <= '0;
                if (s_last) begin
                    s <= '0;
                    b <= b + 1'b1;
                end else begin
                    s <= s + 1'b1;
                end
            end else begin
                p <= p + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntt_core_wmm_clbu_pp_tag_gen_chk.sv
// Tagged multi-lane stimulus generator with an independent in-order checker
// for the returning stream; first error is captured with its word index.
module ntt_core_wmm_clbu_pp_tag_gen_chk
    import ntt_core_wmm_clbu_pp_tag_pkg::*;
#(
    parameter int OP_W        = 64,
    parameter int CHAN_NB     = 8,
    parameter int BATCH_NB_W  = 16,
    parameter int PBS_ID_W    = 4,
    parameter int STG_ITER_W  = 5,
    parameter int STG_ITER_NB = 16
) (
    input  logic                      clk,
    input  logic                      s_rst,
    input  logic                      start,
    input  logic [PBS_ID_W:0]         cfg_pbs_nb,
    input  logic [BATCH_NB_W-1:0]     cfg_batch_nb,
    output logic                      gen_avail,
    output logic [CHAN_NB*OP_W-1:0]   gen_data,
    input  logic                      gen_rdy,
    output logic                      gen_done,
    input  logic                      chk_avail,
    input  logic [CHAN_NB*OP_W-1:0]   chk_data,
    output logic                      chk_rdy,
    output logic                      chk_err,
    output logic [1:0]                chk_err_code,
    output logic [31:0]               chk_err_idx,
    output logic [31:0]               chk_cnt
);

    localparam int VAL_W = OP_W - BATCH_NB_W - PBS_ID_W - STG_ITER_W;
    localparam int TAG_W = BATCH_NB_W + PBS_ID_W + STG_ITER_W;
    localparam logic [PBS_ID_W:0]     PBS_MAX = (PBS_ID_W + 1)'(2 ** PBS_ID_W);
    localparam logic [STG_ITER_W-1:0] S_LAST  = STG_ITER_W'(STG_ITER_NB - 1);

    if (VAL_W < 1) begin : g_val_w_chk
        $error("VAL_W = OP_W - BATCH_NB_W - PBS_ID_W - STG_ITER_W must be at least 1");
    end
    if (STG_ITER_NB > 2 ** STG_ITER_W || OP_W > LANE_MAX_W) begin : g_range_chk
        $error("STG_ITER_NB or OP_W out of range");
    end

    gen_state_e            state_q, state_d;
    logic                  start_ok;
    logic [PBS_ID_W:0]     pbs_nb_fix, pbs_nb_q;
    logic [BATCH_NB_W-1:0] batch_nb_q;
    logic                  gen_xfer, gen_last;
    logic [BATCH_NB_W-1:0] gen_b, exp_b;
    logic [STG_ITER_W-1:0] gen_s, exp_s;
    logic [PBS_ID_W-1:0]   gen_p, exp_p;
    logic [31:0]           gen_w, exp_w;
    logic                  rdy_q, chk_xfer;
    logic [1:0]            err_code_d;

    // Start is honoured only outside RUN, for both halves, so the checker can
    // never be cleared under a generator that keeps going.
    assign start_ok   = start && (state_q != GEN_RUN);
    assign pbs_nb_fix = (cfg_pbs_nb == '0 || cfg_pbs_nb > PBS_MAX) ? (PBS_ID_W + 1)'(1) : cfg_pbs_nb;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q    <= GEN_IDLE;
            pbs_nb_q   <= (PBS_ID_W + 1)'(1);
            batch_nb_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                pbs_nb_q   <= pbs_nb_fix;
                batch_nb_q <= cfg_batch_nb;
            end
        end
    end

    assign gen_xfer = gen_avail && gen_rdy;
    assign gen_last = (batch_nb_q != '0) && (gen_b == batch_nb_q - 1'b1)
                   && ({1'b0, gen_p} == pbs_nb_q - 1'b1) && (gen_s == S_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GEN_IDLE, GEN_DONE: if (start) state_d = GEN_RUN;
            GEN_RUN:            if (gen_xfer && gen_last) state_d = GEN_DONE;
            default:            state_d = GEN_IDLE;
        endcase
    end

    always_comb begin
        gen_avail = (state_q == GEN_RUN);
        gen_done  = (state_q == GEN_DONE);
    end

    ntt_core_wmm_clbu_pp_tag_cnt #(
        .BATCH_NB_W (BATCH_NB_W),
        .PBS_ID_W   (PBS_ID_W),
        .STG_ITER_W (STG_ITER_W),
        .STG_ITER_NB(STG_ITER_NB)
    ) u_gen_cnt (
        .clk   (clk),
        .s_rst (s_rst),
        .clr   (start_ok),
        .adv   (gen_xfer),
        .pbs_nb(pbs_nb_q),
        .b     (gen_b),
        .s     (gen_s),
        .p     (gen_p),
        .w     (gen_w)
    );

    // Word is a pure function of registered counters, so it holds while stalled.
    always_comb begin
        // NOTE: default first, so no path through this block leaves gen_data
        // unassigned and no latch is inferred.
        gen_data = '0;
        if (gen_avail) begin
            for (int c = 0; c < CHAN_NB; c++) begin
                gen_data[c*OP_W +: OP_W] = OP_W'(pack_lane(lane_t'(c) + lane_t'(gen_w),
                    lane_t'(gen_b), lane_t'(gen_p), lane_t'(gen_s),
                    BATCH_NB_W, PBS_ID_W, STG_ITER_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    assign chk_rdy  = rdy_q;
    assign chk_xfer = chk_avail && rdy_q && !start_ok;

    ntt_core_wmm_clbu_pp_tag_cnt #(
        .BATCH_NB_W (BATCH_NB_W),
        .PBS_ID_W   (PBS_ID_W),
        .STG_ITER_W (STG_ITER_W),
        .STG_ITER_NB(STG_ITER_NB)
    ) u_chk_cnt (
        .clk   (clk),
        .s_rst (s_rst),
        .clr   (start_ok),
        .adv   (chk_xfer),
        .pbs_nb(pbs_nb_q),
        .b     (exp_b),
        .s     (exp_s),
        .p     (exp_p),
        .w     (exp_w)
    );

    always_comb begin
        lane_t lane0;
        lane_t lane;
        lane_t exp_tag;
        logic  lane_err, tag_err, val_err;
        lane_err = 1'b0;
        val_err  = 1'b0;
        lane0    = lane_t'(chk_data[OP_W-1:0]);
        lane     = '0;
        // A zero payload makes pack_lane yield just the expected tag bits.
        exp_tag  = pack_lane('0, lane_t'(exp_b), lane_t'(exp_p), lane_t'(exp_s),
                             BATCH_NB_W, PBS_ID_W, STG_ITER_W);
        tag_err  = (unpack_field(lane0, 0, TAG_W) != exp_tag);
        for (int c = 0; c < CHAN_NB; c++) begin
            lane = lane_t'(chk_data[c*OP_W +: OP_W]);
            if (unpack_field(lane, 0, TAG_W) != unpack_field(lane0, 0, TAG_W))
                lane_err = 1'b1;
            if (unpack_field(lane, TAG_W, VAL_W) != unpack_field(lane_t'(c) + lane_t'(exp_w), 0, VAL_W))
                val_err = 1'b1;
        end
        err_code_d = lane_err ? ERR_LANE : tag_err ? ERR_TAG : val_err ? ERR_VAL : ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (s_rst || start_ok) begin
            chk_cnt      <= '0;
            chk_err      <= 1'b0;
            chk_err_code <= ERR_NONE;
            chk_err_idx  <= '0;
        end else if (chk_xfer) begin
            if (chk_cnt != '1) chk_cnt <= chk_cnt + 32'd1;
            if (!chk_err && err_code_d != ERR_NONE) begin
                chk_err      <= 1'b1;
                chk_err_code <= err_code_d;
                chk_err_idx  <= chk_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ntt_core_wmm_clbu_pp_tag_gen_chk.sv
// Directed bench: generator looped back into the checker, with optional
// corruption/drop of one word, stalls, unlimited-mode wrap and mid-run reset.
module tb_ntt_core_wmm_clbu_pp_tag_gen_chk;

    localparam int OP_W        = 64;
    localparam int CHAN_NB     = 8;
    localparam int BATCH_NB_W  = 2;
    localparam int PBS_ID_W    = 4;
    localparam int STG_ITER_W  = 5;
    localparam int STG_ITER_NB = 16;
    localparam int VAL_W       = OP_W - BATCH_NB_W - PBS_ID_W - STG_ITER_W;
    localparam int DW          = CHAN_NB * OP_W;

    logic                  clk = 1'b0;
    logic                  s_rst, start;
    logic [PBS_ID_W:0]     cfg_pbs_nb;
    logic [BATCH_NB_W-1:0] cfg_batch_nb;
    logic                  gen_avail, gen_rdy, gen_done;
    logic [DW-1:0]         gen_data, chk_data;
    logic                  chk_avail, chk_rdy, chk_err;
    logic [1:0]            chk_err_code;
    logic [31:0]           chk_err_idx, chk_cnt;

    int            gen_w = 0;
    int            drop_idx = -1;
    int            corrupt_idx = -1;
    logic [DW-1:0] corrupt_mask = '0;
    logic [DW-1:0] cap [0:127];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    assign chk_avail = gen_avail && gen_rdy && (gen_w != drop_idx);
    assign chk_data  = (gen_w == corrupt_idx) ? (gen_data ^ corrupt_mask) : gen_data;

    ntt_core_wmm_clbu_pp_tag_gen_chk #(
        .OP_W(OP_W), .CHAN_NB(CHAN_NB), .BATCH_NB_W(BATCH_NB_W),
        .PBS_ID_W(PBS_ID_W), .STG_ITER_W(STG_ITER_W), .STG_ITER_NB(STG_ITER_NB)
    ) dut (
        .clk(clk), .s_rst(s_rst), .start(start),
        .cfg_pbs_nb(cfg_pbs_nb), .cfg_batch_nb(cfg_batch_nb),
        .gen_avail(gen_avail), .gen_data(gen_data), .gen_rdy(gen_rdy), .gen_done(gen_done),
        .chk_avail(chk_avail), .chk_data(chk_data), .chk_rdy(chk_rdy),
        .chk_err(chk_err), .chk_err_code(chk_err_code),
        .chk_err_idx(chk_err_idx), .chk_cnt(chk_cnt)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] exp_lane(input int w, input int c, input int pbs);
        logic [VAL_W-1:0] v;
        int p, s, b;
        v = VAL_W'(c + w);
        p = w % pbs;
        s = (w / pbs) % STG_ITER_NB;
        b = (w / (pbs * STG_ITER_NB)) % (2 ** BATCH_NB_W);
        return {v, BATCH_NB_W'(b), PBS_ID_W'(p), STG_ITER_W'(s)};
    endfunction

    function automatic logic [DW-1:0] exp_word(input int w, input int pbs);
        logic [DW-1:0] word;
        for (int c = 0; c < CHAN_NB; c++) word[c*OP_W +: OP_W] = exp_lane(w, c, pbs);
        return word;
    endfunction

    task automatic do_start(input int pbs, input int bnb);
        @(negedge clk);
        cfg_pbs_nb   = (PBS_ID_W + 1)'(pbs);
        cfg_batch_nb = BATCH_NB_W'(bnb);
        start        = 1'b1;
        gen_w        = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until gen_done or n_stop transfers; every presented word is compared
    // with the model and every stalled cycle with the held word.
    task automatic run_words(input int pbs, input int n_stop, input bit rnd);
        bit            pend = 1'b0;
        bit            stalled = 1'b0;
        logic [DW-1:0] held = '0;
        int            budget = 0;
        while (1) begin
            if (pend) gen_w++;
            if (gen_done || gen_w >= n_stop) break;
            if (budget++ > 3000) begin
                check("timeout", 1'b0, 1'b1);
                break;
            end
            if (stalled) begin
                check("stall_hold", gen_data, held);
            end else begin
                check("gen_avail", gen_avail, 1'b1);
                check("gen_word", gen_data, exp_word(gen_w, pbs));
                if (gen_w < 128) cap[gen_w] = gen_data;
            end
            gen_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pend    = gen_avail && gen_rdy;
            stalled = gen_avail && !gen_rdy;
            held    = gen_data;
            @(negedge clk);
        end
        gen_rdy = 1'b0;
    endtask

    task automatic run_err_case(input string name, input logic [1:0] code, input int idx, input int cnt);
        do_start(3, 2);
        run_words(3, 1000, 1'b0);
        check({name, "_err"},  chk_err, 1'b1);
        check({name, "_code"}, chk_err_code, code);
        check({name, "_idx"},  chk_err_idx, 32'(idx));
        check({name, "_cnt"},  chk_cnt, 32'(cnt));
        corrupt_idx  = -1;
        drop_idx     = -1;
        corrupt_mask = '0;
    endtask

    initial begin
        s_rst        = 1'b1;
        start        = 1'b0;
        gen_rdy      = 1'b0;
        cfg_pbs_nb   = '0;
        cfg_batch_nb = '0;
        repeat (3) @(negedge clk);
        check("rst_gen_avail", gen_avail, 1'b0);
        check("rst_gen_done",  gen_done, 1'b0);
        check("rst_gen_data",  gen_data, '0);
        check("rst_chk_rdy",   chk_rdy, 1'b0);
        check("rst_chk_cnt",   chk_cnt, '0);
        s_rst = 1'b0;

        // Full 96-word run, back-to-back.
        do_start(3, 2);
        run_words(3, 1000, 1'b0);
        check("t1_words",   gen_w, 96);
        check("t1_done",    gen_done, 1'b1);
        check("t1_avail",   gen_avail, 1'b0);
        check("t1_chk_cnt", chk_cnt, 32'd96);
        check("t1_chk_err", chk_err, 1'b0);
        check("t1_w0_l5_val", cap[0][5*OP_W + 11 +: VAL_W], VAL_W'(5));
        check("t1_w4_tag",    cap[4][10:0], {2'd0, 4'd1, 5'd1});

        // Same sequence with random backpressure.
        do_start(3, 2);
        run_words(3, 1000, 1'b1);
        check("t2_words",   gen_w, 96);
        check("t2_done",    gen_done, 1'b1);
        check("t2_chk_cnt", chk_cnt, 32'd96);
        check("t2_chk_err", chk_err, 1'b0);

        corrupt_idx = 10;
        corrupt_mask[2*OP_W + 5] = 1'b1;
        run_err_case("t3_lane", 2'd3, 10, 96);

        corrupt_idx = 7;
        for (int c = 0; c < CHAN_NB; c++) corrupt_mask[c*OP_W + 11] = 1'b1;
        run_err_case("t4_val", 2'd2, 7, 96);

        drop_idx = 20;
        run_err_case("t5_drop", 2'd1, 20, 95);

        // Out-of-range pbs count behaves as one pbs per stage iteration.
        do_start(0, 1);
        run_words(1, 1000, 1'b0);
        check("t6_words",   gen_w, 16);
        check("t6_chk_err", chk_err, 1'b0);

        // Unlimited mode: batch_id wraps after batch 3, run never finishes.
        do_start(1, 0);
        run_words(1, 70, 1'b0);
        check("t7_b63",     cap[63][10:9], 2'd3);
        check("t7_b64",     cap[64][10:9], 2'd0);
        check("t7_no_done", gen_done, 1'b0);
        check("t7_chk_cnt", chk_cnt, 32'd70);
        check("t7_chk_err", chk_err, 1'b0);

        s_rst = 1'b1;
        @(negedge clk);
        check("t8_gen_avail", gen_avail, 1'b0);
        check("t8_gen_done",  gen_done, 1'b0);
        check("t8_gen_data",  gen_data, '0);
        check("t8_chk_rdy",   chk_rdy, 1'b0);
        check("t8_chk_err",   chk_err, 1'b0);
        check("t8_err_code",  chk_err_code, 2'd0);
        check("t8_err_idx",   chk_err_idx, 32'd0);
        check("t8_chk_cnt",   chk_cnt, 32'd0);
        s_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t8_chk_rdy_back", chk_rdy, 1'b1);
        check("t8_idle_avail",   gen_avail, 1'b0);

        do_start(1, 0);
        run_words(1, 3, 1'b0);
        check("t9_word0", cap[0], exp_word(0, 1));
        check("t9_chk_err", chk_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
